tmr_counter_ctrl: RTL and testbench
===================================

Name: tmr_counter_ctrl

Overview:
- Run controller and fault manager for the triple-modular-redundant counter datapath: three replica counters, a majority voter, and per-replica mismatch flags.
- Sequences a counting run: clear, count to a programmed target, stop.
- Observes the three replica fault flags, keeps per-replica error statistics and masks replicas that fail persistently.
- Drops to a fail-safe state when majority voting can no longer be trusted.

Parameters:
- WIDTH, 64, width of voted count and target.
- ERR_W, 8, width of each per-replica saturating error counter.
- ERR_THRESH, 16, error count at which a replica is masked; legal range 1..2^ERR_W-1.
- WDOG_CYCLES, 1024, watchdog stall limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  run request, single-cycle pulse; honoured in IDLE and DONE.
- stop  in  1  abort request, honoured in RUN and CHECK.
- alarm_ack  in  1  clears FAILSAFE.
- target  in  WIDTH  terminal count; sampled into an internal register on an accepted start.
- count_q  in  WIDTH  voted count from the TMR datapath.
- fault  in  3  per-replica mismatch flags (bit i = replica i+1 disagrees with the vote).
- cnt_enable  out  1  count enable to all replicas.
- cnt_clear  out  1  one-cycle clear pulse to the datapath counters.
- busy  out  1  high in CLEAR, RUN, CHECK.
- done  out  1  high while in DONE.
- alarm  out  1  high while in FAILSAFE.
- replica_mask  out  3  sticky per-replica masked flags.
- err_cnt  out  3*ERR_W  packed error counters; replica 1 in the LSBs.

Behaviour:
- Reset values: state IDLE; all outputs 0; err_cnt 0; replica_mask 0; target register 0.
- All outputs are decoded from registers; no combinational input-to-output paths.
- cnt_enable = (state==RUN || state==CHECK). cnt_clear = (state==CLEAR).
- IDLE:
  - start -> CLEAR.
  - Accepted start also clears err_cnt and replica_mask and latches target.
- CLEAR (1 cycle):
  - -> DONE if latched target==0.
  - else -> RUN.
- RUN / CHECK, terminal count:
  - If count_q == target-1, the same edge moves to DONE.
  - The final count_q therefore equals target exactly, with no overshoot.
- Fault qualification:
  - f = fault & ~replica_mask; n = popcount(f).
- Fault handling in RUN / CHECK, in priority order:
  1. n>=2, or n==1 while any mask bit is already set -> FAILSAFE.
  2. n==1 -> err_cnt[i] increments, saturating at 2^ERR_W-1.
     - If the incremented value == ERR_THRESH, set replica_mask[i].
     - Go to CHECK and record i.
  3. In CHECK, the same replica i still faulting -> set replica_mask[i] immediately (stuck replica).
     - The datapath self-corrects on one enabled edge, so a repeat means a stuck replica.
  - CHECK lasts one cycle, then -> RUN unless a higher-priority transition applies.
- Priority when events coincide: FAILSAFE > terminal count (DONE) > stop (IDLE) > fault bookkeeping.
  - The terminal-count edge still updates err_cnt and replica_mask.
- stop in RUN/CHECK -> IDLE; done not asserted; err_cnt and replica_mask retained.
- DONE:
  - start -> CLEAR, with the same clearing and latching as in IDLE.
  - Faults are ignored.
- FAILSAFE:
  - cnt_enable=0.
  - alarm_ack -> IDLE. start is ignored.
  - Statistics are retained for readout.
- Reset mid-run: immediate return to reset values; no cnt_clear pulse is generated.

Optional Feature:
- Macro TMR_CTRL_WATCHDOG_EN.
- Defined:
  - Stall counter of width $clog2(WDOG_CYCLES+1).
  - Counts cycles in RUN/CHECK in which count_q is unchanged from the previous cycle.
  - Reset on any change and on leaving RUN/CHECK.
  - Reaching WDOG_CYCLES -> FAILSAFE.
- Undefined: no stall counter; WDOG_CYCLES unused; a stalled datapath keeps the FSM in RUN indefinitely.

Decomposition:
- Package tmr_ctrl_pkg holds:
  - state enum ctrl_state_t {IDLE, CLEAR, RUN, CHECK, DONE, FAILSAFE};
  - NUM_REPLICAS=3;
  - default ERR_W and ERR_THRESH.
- One sub-module, tmr_err_tracker: one instance per replica, holding the saturating error counter and the sticky mask bit.
  - Inputs: inc, clr, stuck.
  - Outputs: cnt, mask.

Test Plan:
- Clean run: target=10, start -> cnt_clear 1 cycle, cnt_enable high 10 cycles, count_q==10 at DONE, done=1, err_cnt=0.
- Single transient: fault=3'b010 for 1 cycle at count 4 -> err_cnt[1]=1, one CHECK cycle, no mask, DONE with count_q==target.
- Stuck replica: fault[2] held high -> err_cnt[2]=2, replica_mask=3'b100 after CHECK, run continues to DONE.
- Threshold: ERR_THRESH=3, three isolated fault[0] pulses -> replica_mask[0] set on the third; a later fault[1] -> FAILSAFE, alarm=1; alarm_ack -> IDLE.
- Double fault and abort: fault=3'b011 in RUN -> FAILSAFE next edge, cnt_enable=0. Separately, stop at count 5 -> IDLE, done=0. target=0 -> CLEAR then DONE with no enable cycle.
- Watchdog (macro defined, WDOG_CYCLES=8): count_q frozen in RUN -> FAILSAFE after 8 cycles. Macro undefined -> stays in RUN.

Source files
------------

// File: rtl/tmr_ctrl_pkg.sv
// Shared types and defaults for the TMR counter run controller.
// Holds the controller state encoding, replica count and a popcount helper.
package tmr_ctrl_pkg;

  localparam int NUM_REPLICAS   = 3;
  localparam int ERR_W_DEF      = 8;
  localparam int ERR_THRESH_DEF = 16;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLEAR    = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_CHECK    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_FAILSAFE = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    CLEAR    = ST_CLEAR,
    RUN      = ST_RUN,
    CHECK    = ST_CHECK,
    DONE     = ST_DONE,
    FAILSAFE = ST_FAILSAFE
  } ctrl_state_t;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/tmr_err_tracker.sv
// Per-replica fault statistics: saturating error counter plus sticky mask bit.
// The mask sets when the count reaches ERR_THRESH or when the replica is reported stuck.
module tmr_err_tracker #(
  parameter int ERR_W      = 8,
  parameter int ERR_THRESH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             stuck_i,
  output logic [ERR_W-1:0] cnt_o,
  output logic             mask_o
);

  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] THRESH  = ERR_W'(ERR_THRESH);

  logic [ERR_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic             mask_q, mask_d;

  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ERR_W'(1);

  // Next counter / mask value; clear wins over any bookkeeping
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (clr_i) begin
      cnt_d  = {ERR_W{1'b0}};
      mask_d = 1'b0;
    end else begin
      if (inc_i) begin
        cnt_d = cnt_inc_s;
      end else begin
        cnt_d = cnt_q;
      end
      mask_d = mask_q | stuck_i | (inc_i & (cnt_inc_s == THRESH));
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {ERR_W{1'b0}};
      mask_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign mask_o = mask_q;

endmodule

// File: rtl/tmr_counter_ctrl.sv
// Run controller and fault manager for the triple-modular-redundant counter datapath.
// Optional stall watchdog enabled by defining TMR_CTRL_WATCHDOG_EN.
module tmr_counter_ctrl
  import tmr_ctrl_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int ERR_W       = ERR_W_DEF,
  parameter int ERR_THRESH  = ERR_THRESH_DEF,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic                            stop_i,
  input  logic                            alarm_ack_i,
  input  logic [WIDTH-1:0]                target_i,
  input  logic [WIDTH-1:0]                count_q_i,
  input  logic [NUM_REPLICAS-1:0]         fault_i,
  output logic                            cnt_enable_o,
  output logic                            cnt_clear_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            alarm_o,
  output logic [NUM_REPLICAS-1:0]         replica_mask_o,
  output logic [NUM_REPLICAS*ERR_W-1:0]   err_cnt_o
);

  ctrl_state_t       state_q, state_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [2:0]        rec_q, rec_d;
  logic [2:0]        f_s, inc_s, stuck_s;
  logic [1:0]        n_s;
  logic              run_s, fs_s, term_s, book_s, clr_s, wdog_trip_s;

  assign run_s  = (state_q == RUN) || (state_q == CHECK);
  assign f_s    = fault_i & ~replica_mask_o;
  assign n_s    = popcount3(f_s);
  assign term_s = (count_q_i == (target_q - WIDTH'(1)));
  assign clr_s  = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign fs_s   = run_s && ((n_s >= 2'd2) || ((n_s == 2'd1) && (|replica_mask_o)) || wdog_trip_s);
  // Stop outranks bookkeeping, but the terminal-count edge still records the fault
  assign book_s  = run_s && !fs_s && (term_s || !stop_i) && (n_s == 2'd1);
  assign inc_s   = book_s ? f_s : 3'b000;
  assign stuck_s = (book_s && (state_q == CHECK)) ? (f_s & rec_q) : 3'b000;

`ifdef TMR_CTRL_WATCHDOG_EN
  localparam int STALL_W = $clog2(WDOG_CYCLES + 1);

  logic [WIDTH-1:0]   prev_q;
  logic [STALL_W-1:0] stall_q, stall_d;

  // Stall length while counting; any movement or leaving RUN/CHECK restarts it
  always_comb begin
    if (run_s && (count_q_i == prev_q)) begin
      stall_d = stall_q + STALL_W'(1);
    end else begin
      stall_d = {STALL_W{1'b0}};
    end
  end

  assign wdog_trip_s = (stall_d == STALL_W'(WDOG_CYCLES));

  // Watchdog history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= {WIDTH{1'b0}};
      stall_q <= {STALL_W{1'b0}};
    end else begin
      prev_q  <= count_q_i;
      stall_q <= stall_d;
    end
  end
`else
  assign wdog_trip_s = (WDOG_CYCLES < 0);
`endif

  // Run sequencing and fault-driven transitions
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    rec_d    = rec_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = CLEAR;
          target_d = target_i;
        end else begin
          state_d  = state_q;
        end
      end
      CLEAR: begin
        if (target_q == {WIDTH{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN, CHECK: begin
        if (fs_s) begin
          state_d = FAILSAFE;
        end else if (term_s) begin
          state_d = DONE;
        end else if (stop_i) begin
          state_d = IDLE;
        end else if (n_s == 2'd1) begin
          state_d = CHECK;
        end else begin
          state_d = RUN;
        end
        if (book_s) begin
          rec_d = f_s;
        end else begin
          rec_d = rec_q;
        end
      end
      FAILSAFE: begin
        if (alarm_ack_i) begin
          state_d = IDLE;
        end else begin
          state_d = FAILSAFE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= {WIDTH{1'b0}};
      rec_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      rec_q    <= rec_d;
    end
  end

  for (genvar i = 0; i < NUM_REPLICAS; i++) begin : g_trk
    tmr_err_tracker #(
      .ERR_W      (ERR_W),
      .ERR_THRESH (ERR_THRESH)
    ) u_trk (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_s),
      .inc_i   (inc_s[i]),
      .stuck_i (stuck_s[i]),
      .cnt_o   (err_cnt_o[i*ERR_W +: ERR_W]),
      .mask_o  (replica_mask_o[i])
    );
  end

  assign cnt_enable_o = run_s;
  assign cnt_clear_o  = (state_q == CLEAR);
  assign busy_o       = (state_q == CLEAR) || run_s;
  assign done_o       = (state_q == DONE);
  assign alarm_o      = (state_q == FAILSAFE);

endmodule

// File: tb/tb_tmr_counter_ctrl.sv
// Scoreboard bench for tmr_counter_ctrl with a behavioural counter datapath.
// Expectations follow TMR_CTRL_WATCHDOG_EN when the watchdog scenario runs.
module tb_tmr_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, stop_i = 1'b0, alarm_ack_i = 1'b0;
  logic [63:0] target_i = 64'd0;
  logic [63:0] dp_q = 64'd0;
  logic [2:0]  fault_i = 3'b000;
  logic        cnt_enable_o, cnt_clear_o, busy_o, done_o, alarm_o;
  logic [2:0]  replica_mask_o;
  logic [23:0] err_cnt_o;
  logic        freeze = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        done;
    logic        alarm;
    logic [63:0] count;
    logic [23:0] err;
    logic [2:0]  mask;
    int          en;
    int          clr;
    bit          chk_en;
  } exp_t;

  exp_t sb_q[$];

  tmr_counter_ctrl #(
    .WIDTH(64), .ERR_W(8), .ERR_THRESH(3), .WDOG_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .alarm_ack_i(alarm_ack_i),
    .target_i(target_i), .count_q_i(dp_q), .fault_i(fault_i),
    .cnt_enable_o(cnt_enable_o), .cnt_clear_o(cnt_clear_o), .busy_o(busy_o),
    .done_o(done_o), .alarm_o(alarm_o), .replica_mask_o(replica_mask_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  // Replica datapath model: clear pulse zeroes, enable increments unless frozen
  always @(posedge clk) begin
    if (cnt_clear_o) dp_q <= 64'd0;
    else if (cnt_enable_o && !freeze) dp_q <= dp_q + 64'd1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic expect_ev(input string nm, input logic d, input logic a, input logic [63:0] c,
                           input logic [23:0] e, input logic [2:0] m, input int en, input int clr,
                           input bit chk_en);
    exp_t x;
    x.name = nm; x.done = d; x.alarm = a; x.count = c; x.err = e; x.mask = m;
    x.en = en; x.clr = clr; x.chk_en = chk_en;
    sb_q.push_back(x);
  endtask

  // Monitor: an event is the end of a busy period or the release of the alarm
  initial begin
    int en_cnt = 0, clr_cnt = 0;
    logic busy_prev = 1'b0, alarm_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      en_cnt += int'(cnt_enable_o);
      clr_cnt += int'(cnt_clear_o);
      if ((busy_prev && !busy_o) || (alarm_prev && !alarm_o)) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=busy%0b_alarm%0b required=none", busy_o, alarm_o);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, ".done"}, {63'd0, done_o}, {63'd0, e.done});
          chk({e.name, ".alarm"}, {63'd0, alarm_o}, {63'd0, e.alarm});
          chk({e.name, ".count"}, dp_q, e.count);
          chk({e.name, ".err"}, {40'd0, err_cnt_o}, {40'd0, e.err});
          chk({e.name, ".mask"}, {61'd0, replica_mask_o}, {61'd0, e.mask});
          chk({e.name, ".clr_cycles"}, 64'(clr_cnt), 64'(e.clr));
          if (e.chk_en) chk({e.name, ".en_cycles"}, 64'(en_cnt), 64'(e.en));
        end
        en_cnt = 0;
        clr_cnt = 0;
      end
      busy_prev = busy_o;
      alarm_prev = alarm_o;
    end
  end

  task automatic do_start(input logic [63:0] t);
    target_i = t;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic pulse(input int which);
    if (which == 0) stop_i = 1'b1;
    else if (which == 1) alarm_ack_i = 1'b1;
    else start_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    alarm_ack_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic wait_count(input logic [63:0] v);
    bit hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      if (dp_q == v) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_count actual=%0d required=%0d", dp_q, v);
    end
  endtask

  task automatic fault_pulse(input logic [63:0] v, input logic [2:0] f);
    wait_count(v);
    fault_i = f;
    @(negedge clk);
    fault_i = 3'b000;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.enable", {63'd0, cnt_enable_o}, 64'd0);
    chk("reset.clear", {63'd0, cnt_clear_o}, 64'd0);
    chk("reset.busy", {63'd0, busy_o}, 64'd0);
    chk("reset.done", {63'd0, done_o}, 64'd0);
    chk("reset.alarm", {63'd0, alarm_o}, 64'd0);
    chk("reset.mask", {61'd0, replica_mask_o}, 64'd0);
    chk("reset.err", {40'd0, err_cnt_o}, 64'd0);

    expect_ev("clean", 1'b1, 1'b0, 64'd10, 24'h000000, 3'b000, 10, 1, 1'b1);
    do_start(64'd10);
    wait_idle();

    expect_ev("transient", 1'b1, 1'b0, 64'd10, 24'h000100, 3'b000, 10, 1, 1'b1);
    do_start(64'd10);
    fault_pulse(64'd4, 3'b010);
    wait_idle();

    // Replica 3 held faulty from count 3 until the run completes
    expect_ev("stuck", 1'b1, 1'b0, 64'd10, 24'h020000, 3'b100, 10, 1, 1'b1);
    do_start(64'd10);
    wait_count(64'd3);
    fault_i = 3'b100;
    wait_idle();
    fault_i = 3'b000;

    expect_ev("thresh_fs", 1'b0, 1'b1, 64'd21, 24'h000003, 3'b001, 21, 1, 1'b1);
    do_start(64'd40);
    fault_pulse(64'd5, 3'b001);
    fault_pulse(64'd10, 3'b001);
    fault_pulse(64'd15, 3'b001);
    fault_pulse(64'd20, 3'b010);
    wait_idle();
    pulse(2);
    @(negedge clk);
    chk("failsafe_ignores_start", {63'd0, alarm_o}, 64'd1);
    expect_ev("thresh_ack", 1'b0, 1'b0, 64'd21, 24'h000003, 3'b001, 0, 0, 1'b1);
    pulse(1);
    wait_idle();

    expect_ev("double_fs", 1'b0, 1'b1, 64'd7, 24'h000000, 3'b000, 7, 1, 1'b1);
    do_start(64'd20);
    fault_pulse(64'd6, 3'b011);
    wait_idle();
    expect_ev("double_ack", 1'b0, 1'b0, 64'd7, 24'h000000, 3'b000, 0, 0, 1'b1);
    pulse(1);
    wait_idle();

    expect_ev("stop", 1'b0, 1'b0, 64'd6, 24'h000000, 3'b000, 6, 1, 1'b1);
    do_start(64'd20);
    wait_count(64'd5);
    pulse(0);
    wait_idle();

    expect_ev("target0", 1'b1, 1'b0, 64'd0, 24'h000000, 3'b000, 0, 1, 1'b1);
    do_start(64'd0);
    wait_idle();

`ifdef TMR_CTRL_WATCHDOG_EN
    expect_ev("wdog_fs", 1'b0, 1'b1, 64'd10, 24'h000000, 3'b000, 19, 1, 1'b1);
    do_start(64'd100);
    wait_count(64'd10);
    freeze = 1'b1;
    wait_idle();
    expect_ev("wdog_ack", 1'b0, 1'b0, 64'd10, 24'h000000, 3'b000, 0, 0, 1'b1);
    pulse(1);
    wait_idle();
`else
    expect_ev("stall_stop", 1'b0, 1'b0, 64'd10, 24'h000000, 3'b000, 0, 1, 1'b0);
    do_start(64'd100);
    wait_count(64'd10);
    freeze = 1'b1;
    repeat (40) @(negedge clk);
    chk("stall.busy", {63'd0, busy_o}, 64'd1);
    chk("stall.alarm", {63'd0, alarm_o}, 64'd0);
    pulse(0);
    wait_idle();
`endif
    freeze = 1'b0;

    // Asynchronous reset in the middle of a run
    expect_ev("reset_mid", 1'b0, 1'b0, 64'd3, 24'h000000, 3'b000, 4, 1, 1'b1);
    do_start(64'd10);
    wait_count(64'd3);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle();
    chk("reset_mid.clear", {63'd0, cnt_clear_o}, 64'd0);
    chk("reset_mid.done", {63'd0, done_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
